// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  // Values match the RV32M/RV64M funct3 field.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // rs1 is treated as two's complement.
  function automatic logic is_signed_a(input muldiv_op_t op);
    return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) ||
           (op == OpRem);
  endfunction

  // rs2 is treated as two's complement.
  function automatic logic is_signed_b(input muldiv_op_t op);
    return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // REM/REMU return the remainder half of the divider accumulator.
  function automatic logic is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Handshake bundle between the EX stage (master) and the multiply/divide unit (slave).
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_step.sv
// Combinational datapath slice: BITS_PER_CYCLE iterations of shift-add multiply or
// restoring divide on the {hi, lo} accumulator.
// Multiply: acc = {partial product, remaining multiplier}, operand = multiplicand.
// Divide:   acc = {partial remainder, remaining dividend/quotient}, operand = divisor.
module muldiv_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;

  // Unrolled iterations; each one retires a single multiplier or quotient bit.
  always_comb begin
    w_acc = i_acc;
    w_sum = '0;
    w_rem = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i_is_div) begin
        // Shift the next dividend bit into the remainder, keep carry headroom.
        w_rem = w_acc[2*XLEN-1:XLEN-1];
        if (w_rem >= {1'b0, i_operand}) begin
          w_rem = w_rem - {1'b0, i_operand};
          w_acc = {w_rem[XLEN-1:0], w_acc[XLEN-2:0], 1'b1};
        end else begin
          w_acc = {w_rem[XLEN-1:0], w_acc[XLEN-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} +
                (w_acc[0] ? {1'b0, i_operand} : {(XLEN + 1){1'b0}});
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Optional build macro MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle full-width
// multiply at the handshake; DIV* ops remain iterative.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned     Steps   = XLEN / BITS_PER_CYCLE;
  localparam int unsigned     CntW    = $clog2(Steps + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(Steps);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

  muldiv_state_t     r_state, w_state_nxt;
  muldiv_op_t        r_op, w_op_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic              r_neg, w_neg_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;

  muldiv_op_t        w_op;
  logic              w_in_fire;
  logic              w_load;
  logic              w_is_div;
  logic              w_a_neg, w_b_neg, w_in_neg;
  logic              w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic [XLEN-1:0]   w_div_raw, w_fix_res;
  logic [2*XLEN-1:0] w_step_acc, w_prod;

  // Handshake-side decode: operand magnitudes, result sign and special cases.
  always_comb begin
    w_op       = muldiv_op_t'(bus.op);
    w_in_fire  = bus.in_valid & bus.in_ready;
    w_a_neg    = is_signed_a(w_op) & bus.a[XLEN-1];
    w_b_neg    = is_signed_b(w_op) & bus.b[XLEN-1];
    w_a_mag    = w_a_neg ? -bus.a : bus.a;
    w_b_mag    = w_b_neg ? -bus.b : bus.b;
    // Remainder follows the dividend; products and quotients take the XOR.
    w_in_neg   = is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = is_div(w_op) & (bus.b == '0);
    w_div_ovf  = ((w_op == OpDiv) || (w_op == OpRem)) & (bus.a == MinNeg) & (&bus.b);
    w_special  = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_special_res = is_rem(w_op) ? bus.a : '1;
    end else begin
      w_special_res = is_rem(w_op) ? '0 : bus.a;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag, w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;

  // Single-cycle product of the magnitudes, sign-corrected and half-selected.
  always_comb begin
    w_fast_mag  = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
    w_fast_prod = w_in_neg ? -w_fast_mag : w_fast_mag;
    w_fast_res  = (w_op == OpMul) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
  end
`endif

  assign w_is_div = is_div(r_op);

  muldiv_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_operand(r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign fix-up on the accumulator as it leaves the final step.
  always_comb begin
    w_prod    = r_neg ? -w_step_acc : w_step_acc;
    w_div_raw = is_rem(r_op) ? w_step_acc[2*XLEN-1:XLEN] : w_step_acc[XLEN-1:0];
    if (w_is_div) begin
      w_fix_res = r_neg ? -w_div_raw : w_div_raw;
    end else if (r_op == OpMul) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state and datapath register updates; flush overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_neg_nxt    = r_neg;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_load       = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_load = w_in_fire;
        CALC: begin
          w_acc_nxt = w_step_acc;
          if (r_cnt == CntOne) begin
            w_result_nxt = w_fix_res;
            w_state_nxt  = DONE;
          end else begin
            w_cnt_nxt = r_cnt - CntOne;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            w_state_nxt = IDLE;
            w_load      = w_in_fire;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_load) begin
        w_op_nxt   = w_op;
        w_neg_nxt  = w_in_neg;
        w_cnt_nxt  = CntLoad;
        w_acc_nxt  = {{XLEN{1'b0}}, (is_div(w_op) ? w_a_mag : w_b_mag)};
        w_opnd_nxt = is_div(w_op) ? w_b_mag : w_a_mag;
        if (w_special) begin
          w_result_nxt = w_special_res;
          w_state_nxt  = DONE;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div(w_op)) begin
          w_result_nxt = w_fast_res;
          w_state_nxt  = DONE;
        end
`endif
        else begin
          w_state_nxt = CALC;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= OpMul;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_acc    <= w_acc_nxt;
      r_opnd   <= w_opnd_nxt;
      r_neg    <= w_neg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.in_ready  = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.result    = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit at XLEN=32, BITS_PER_CYCLE=1.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int          CalcLat = 33;

  logic clk;
  logic rst_n;
  logic flush;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];
  string       sb_tag[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on 64-bit arithmetic and SV signed division.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sbv, ua, ub, p;
    int          ia, ib;
    logic [31:0] res;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res = '0;
    p   = '0;
    case (op)
      3'b000: begin p = sa * sbv; res = p[31:0];  end
      3'b001: begin p = sa * sbv; res = p[63:32]; end
      3'b010: begin p = sa * ub;  res = p[63:32]; end
      3'b011: begin p = ua * ub;  res = p[63:32]; end
      3'b100: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'b101: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: res = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Handshake edge counts as cycle 1.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return CalcLat;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Inputs change 1 time unit after posedge; returns just after the handshake edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push, output int waits);
    waits        = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) check_eq({tag, "_in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
    if (push) begin
      sb_q.push_back(model(op, a, b));
      sb_tag.push_back(tag);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble operands to show they are sampled only at the handshake.
    bus.op = 3'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int waits, lat;
    do_op(tag, op, a, b, 1'b1, waits);
    wait_valid(lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat(op, a, b)));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result_count", 64'(sb_q.size()), 64'd1);
      end else begin
        check_eq(sb_tag.pop_front(), 64'(bus.result), 64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waits, lat;
    bit  seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    flush         = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_7_m3", OpMul, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu_ff", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_ff", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_mix", OpMulhsu, 32'hFFFF_FFFE, 32'h8000_0000);
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_5_0", OpDivu, 32'd5, 32'd0);
    run_op("rem_5_0", OpRem, 32'd5, 32'd0);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the middle of CALC.
    do_op("flush_op", OpMul, 32'd5, 32'd6, 1'b0, waits);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);

    // Flush on the same edge as a handshake discards it.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op       = OpDivu;
    bus.a        = 32'd5;
    bus.b        = 32'd0;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check_eq("flush_hs_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_hs_out_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in the middle of CALC.
    do_op("rst_op", OpDiv, 32'd100, 32'd7, 1'b0, waits);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("arst_result", 64'(bus.result), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Result held in DONE while out_ready is low, then accept plus new op on one edge.
    bus.out_ready = 1'b0;
    do_op("hold_mulhsu", OpMulhsu, 32'h8000_0001, 32'hFFFF_0000, 1'b1, waits);
    wait_valid(lat);
    check_eq("hold_latency", 64'(lat), 64'(exp_lat(OpMulhsu, 32'h8000_0001, 32'hFFFF_0000)));
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_result", 64'(bus.result), 64'(sb_q[0]));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    do_op("b2b_remu", OpRemu, 32'd10, 32'd3, 1'b1, waits);
    check_eq("b2b_accept_waits", 64'(waits), 64'd0);
    wait_valid(lat);
    check_eq("b2b_latency", 64'(lat), 64'(exp_lat(OpRemu, 32'd10, 32'd3)));
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
    end

    repeat (2) @(posedge clk);
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
